regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipelined core; successor to the single-write, two-read pipeline register file.
- Adds configurable width, depth and read-port count, and a second write port for load return.
- Adds an asynchronous clear, optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard used by decode to detect load-use hazards.

---
 rtl/regfile_mp.sv | 59 +++++
 tb/tb_regfile_mp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with dual write ports, optional same-cycle
// bypass and a per-register load-pending scoreboard.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]    rpend,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [XLEN-1:0]   wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [XLEN-1:0]   wd1,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              any_pend
);
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] pend, pend_nxt, set_m, clr_m;
  logic w0, w1;
  assign w0 = we0 && !(ZERO_REG && wa0 == '0);
  assign w1 = we1 && !(ZERO_REG && wa1 == '0);
  // set applied after clear so back-to-back loads to one register stay pending
  always_comb begin
    set_m = '0;
    clr_m = '0;
    set_m[iss_addr] = iss_en && !(ZERO_REG && iss_addr == '0);
    clr_m[wa1] = we1;
    pend_nxt = (pend & ~clr_m) | set_m;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      pend <= '0;
    end else begin
      if (w0) rf[wa0] <= wd0;
      if (w1) rf[wa1] <= wd1;
      pend <= pend_nxt;
    end
  assign any_pend = |pend;
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic z, b0, b1;
    assign a = ra[g*AW +: AW];
    assign z = ZERO_REG && a == '0;
    assign b1 = BYPASS && we1 && wa1 == a;
    assign b0 = BYPASS && we0 && wa0 == a;
    assign rd[g*XLEN +: XLEN] = (!rst_n || z) ? '0 : b1 ? wd1 : b0 ? wd0 : rf[a];
    assign rpend[g] = rst_n && !b1 && pend[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, corner sequences and random traffic against a reference model,
// covering the default configuration and a no-bypass/no-zero-register variant.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] ra;
  logic we0, we1, iss_en;
  logic [4:0] wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic [63:0] rd_a, rd_b;
  logic [1:0] rpend_a, rpend_b;
  logic ap_a, ap_b;
  int total = 0;
  int bad = 0;
  logic [31:0] mrf [2][32];
  logic mpend [2][32];

  regfile_mp dut_a (.clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_a), .rpend(rpend_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .any_pend(ap_a));
  regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .ra(ra),
    .rd(rd_b), .rpend(rpend_b), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
    .wd1(wd1), .iss_en(iss_en), .iss_addr(iss_addr), .any_pend(ap_b));

  always #5 clk = ~clk;

  typedef struct {
    logic we0; logic [4:0] wa0; logic [31:0] wd0;
    logic we1; logic [4:0] wa1; logic [31:0] wd1;
    logic iss; logic [4:0] ia;
    logic [4:0] ra0, ra1;
    logic [31:0] e0, e1; logic [1:0] erp; logic eap;
  } vec_t;
  vec_t tv [14];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 32; r++) begin
        mrf[c][r] = '0;
        mpend[c][r] = 1'b0;
      end
  endtask

  // c=0: zero register and bypass on; c=1: both off
  function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
    if (!rst_n || (c == 0 && a == 0)) return '0;
    if (c == 0 && we1 && wa1 == a) return wd1;
    if (c == 0 && we0 && wa0 == a) return wd0;
    return mrf[c][a];
  endfunction

  function automatic logic exp_rp(input int c, input logic [4:0] a);
    if (!rst_n || (c == 0 && we1 && wa1 == a)) return 1'b0;
    return mpend[c][a];
  endfunction

  function automatic logic exp_ap(input int c);
    logic any = 1'b0;
    for (int r = 0; r < 32; r++) any |= mpend[c][r];
    return any;
  endfunction

  task automatic model_check();
    for (int c = 0; c < 2; c++) begin
      logic [63:0] rdv;
      logic [1:0] rpv;
      rdv = (c == 0) ? rd_a : rd_b;
      rpv = (c == 0) ? rpend_a : rpend_b;
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = ra[p*5 +: 5];
        chk($sformatf("model_rd c%0d p%0d a%0d", c, p, a), rdv[p*32 +: 32], exp_rd(c, a));
        chk($sformatf("model_rpend c%0d p%0d a%0d", c, p, a), {31'b0, rpv[p]}, {31'b0, exp_rp(c, a)});
      end
      chk($sformatf("model_any_pend c%0d", c), {31'b0, (c == 0) ? ap_a : ap_b}, {31'b0, exp_ap(c)});
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < 2; c++) begin
      if (we0 && !(c == 0 && wa0 == 0)) mrf[c][wa0] = wd0;
      if (we1 && !(c == 0 && wa1 == 0)) mrf[c][wa1] = wd1;
      if (we1) mpend[c][wa1] = 1'b0;
      if (iss_en && !(c == 0 && iss_addr == 0)) mpend[c][iss_addr] = 1'b1;
    end
  endtask

  // called shortly after a falling edge with inputs already driven
  task automatic tick();
    #1;
    if (!rst_n) model_clear();
    model_check();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_en = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_addr = 0;
  endtask

  initial begin
    tv[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 3, 'h12345678, 0, 0, 0, 0, 0, 3, 3, 'h12345678, 'h12345678, 0, 0};
    tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 'h12345678, 0, 0, 0};
    tv[3]  = '{1, 7, 'h11111111, 1, 7, 'h22222222, 0, 0, 7, 3, 'h22222222, 'h12345678, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 'h22222222, 'h22222222, 0, 0};
    tv[5]  = '{0, 0, 0, 1, 0, 'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[7]  = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 0, 0, 0, 0};
    tv[8]  = '{1, 9, 'hAAAA5555, 0, 0, 0, 0, 0, 9, 1, 'hAAAA5555, 0, 1, 1};
    tv[9]  = '{0, 0, 0, 1, 9, 'hCAFE0000, 0, 0, 9, 9, 'hCAFE0000, 'hCAFE0000, 0, 1};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 4, 'hCAFE0000, 0, 0, 0};
    tv[11] = '{0, 0, 0, 0, 0, 0, 1, 4, 4, 9, 0, 'hCAFE0000, 0, 0};
    tv[12] = '{0, 0, 0, 1, 4, 'h44444444, 1, 4, 4, 4, 'h44444444, 'h44444444, 0, 1};
    tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 9, 'h44444444, 'hCAFE0000, 1, 1};
    rst_n = 0;
    ra = '0;
    idle();
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rd", rd_a[31:0], 32'h0);
    chk("reset_any_pend", {31'b0, ap_a}, 32'h0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      we0 = tv[i].we0; wa0 = tv[i].wa0; wd0 = tv[i].wd0;
      we1 = tv[i].we1; wa1 = tv[i].wa1; wd1 = tv[i].wd1;
      iss_en = tv[i].iss; iss_addr = tv[i].ia;
      ra = {tv[i].ra1, tv[i].ra0};
      #1;
      chk($sformatf("tv%0d rd0", i), rd_a[31:0], tv[i].e0);
      chk($sformatf("tv%0d rd1", i), rd_a[63:32], tv[i].e1);
      chk($sformatf("tv%0d rpend", i), {30'b0, rpend_a}, {30'b0, tv[i].erp});
      chk($sformatf("tv%0d any_pend", i), {31'b0, ap_a}, {31'b0, tv[i].eap});
      tick();
    end
    idle();
    ra = {5'd9, 5'd0};
    #1;
    chk("zero_reg_a", rd_a[31:0], 32'h0);
    chk("no_zero_reg_b", rd_b[31:0], 32'hFFFFFFFF);
    tick();
    // asynchronous clear in the middle of a cycle
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
    tick();
    idle();
    iss_en = 1; iss_addr = 6;
    tick();
    idle();
    ra = {5'd6, 5'd5};
    #1;
    chk("pre_reset_r5", rd_a[31:0], 32'hDEADBEEF);
    chk("pre_reset_any_pend", {31'b0, ap_a}, 32'h1);
    #1;
    rst_n = 0;
    model_clear();
    #1;
    chk("async_reset_r5", rd_a[31:0], 32'h0);
    chk("async_reset_rpend", {30'b0, rpend_a}, 32'h0);
    chk("async_reset_any_pend", {31'b0, ap_a}, 32'h0);
    @(negedge clk);
    we0 = 1; wa0 = 5; wd0 = 32'h55555555; iss_en = 1; iss_addr = 5;
    tick();
    idle();
    rst_n = 1;
    #1;
    chk("post_reset_r5", rd_a[31:0], 32'h0);
    chk("post_reset_any_pend", {31'b0, ap_a}, 32'h0);
    tick();
    // write visibility without bypass
    we0 = 1; wa0 = 3; wd0 = 32'h12345678;
    ra = {5'd3, 5'd3};
    #1;
    chk("bypass_same_cycle_a", rd_a[31:0], 32'h12345678);
    chk("nobypass_same_cycle_b", rd_b[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("nobypass_next_cycle_b", rd_b[31:0], 32'h12345678);
    tick();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      we0 = $urandom_range(0, 1); wa0 = $urandom_range(0, 7); wd0 = $urandom;
      we1 = $urandom_range(0, 2) == 0; wa1 = $urandom_range(0, 7); wd1 = $urandom;
      iss_en = $urandom_range(0, 2) == 0; iss_addr = $urandom_range(0, 7);
      ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 9) == 0) ra[4:0] = 5'($urandom_range(0, 31));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
